// File: rtl/gem_link_sync_mon.sv
// GEM fiber K-char sync monitor: per-OH and cross-OH debounced sync FSMs.
// Loss counters are built only when GEM_SYNC_LOSS_CNT_EN is defined.
module gem_link_sync_mon #(
  parameter int NOH         = 2,
  parameter int FPO         = 2,
  parameter int KW          = 8,
  parameter int LOSS_THRESH = 4,
  parameter int LOCK_THRESH = 16,
  parameter int CNTW        = 16,
  localparam int NFIB       = NOH * FPO,
  localparam int OHW        = (NOH > 1) ? $clog2(NOH) : 1
) (
  input  logic                clock,
  input  logic                global_reset,
  input  logic                ttc_resync,
  input  logic [NFIB*KW-1:0]  kchar,
  input  logic [NFIB-1:0]     fiber_mask,
  output logic [NOH-1:0]      oh_synced,
  output logic                all_synced,
  output logic [NOH-1:0]      oh_lostsync,
  output logic                all_lostsync,
  output logic [NOH*CNTW-1:0] oh_loss_cnt,
  output logic [OHW-1:0]      first_bad_oh,
  output logic                first_bad_valid
);

  localparam int NF = NOH + 1;
  localparam logic [7:0] LOSS_T = LOSS_THRESH[7:0];
  localparam logic [7:0] LOCK_T = LOCK_THRESH[7:0];

  typedef enum logic [1:0] {
    S_SYNC, S_SUSP, S_LOST, S_RELK
  } st_e;

  logic          clr;
  logic [NOH-1:0] m_d, m_q;
  logic          mx_d, mx_q;
  logic          have_ref, have_x;
  logic [KW-1:0] grp_ref, x_ref;

  assign clr = global_reset | ttc_resync;

  always_comb begin
    m_d      = '1;
    mx_d     = 1'b1;
    have_ref = 1'b0;
    have_x   = 1'b0;
    grp_ref  = '0;
    x_ref    = '0;
    for (int g = 0; g < NOH; g++) begin
      have_ref = 1'b0;
      grp_ref  = '0;
      for (int f = 0; f < FPO; f++) begin
        if (!fiber_mask[g*FPO+f]) begin
          if (!have_ref) begin
            have_ref = 1'b1;
            grp_ref  = kchar[(g*FPO+f)*KW +: KW];
          end else if (kchar[(g*FPO+f)*KW +: KW] != grp_ref) begin
            m_d[g] = 1'b0;
          end
        end
      end
      if (have_ref) begin
        if (!have_x) begin
          have_x = 1'b1;
          x_ref  = grp_ref;
        end else if (grp_ref != x_ref) begin
          mx_d = 1'b0;
        end
      end
    end
    mx_d = mx_d & (&m_d);
  end

  st_e           st_d   [NF];
  st_e           st_q   [NF];
  logic [7:0]    cnt_d  [NF];
  logic [7:0]    cnt_q  [NF];
  logic [NF-1:0] mv;
  logic [NF-1:0] loss_ev;
  logic [NF-1:0] sync_d, sync_q;

  assign mv = {mx_q, m_q};

  // A loss event is a drop out of sync; RELOCK falling back to LOST
  // is not a new loss and is not counted again.
  always_comb begin
    for (int i = 0; i < NF; i++) begin
      st_d[i]    = st_q[i];
      cnt_d[i]   = cnt_q[i];
      loss_ev[i] = 1'b0;
      unique case (st_q[i])
        S_SYNC: if (!mv[i]) begin
          if (LOSS_T == 8'd1) begin
            st_d[i]    = S_LOST;
            cnt_d[i]   = 8'd0;
            loss_ev[i] = 1'b1;
          end else begin
            st_d[i]  = S_SUSP;
            cnt_d[i] = 8'd1;
          end
        end
        S_SUSP: if (mv[i]) begin
          st_d[i]  = S_SYNC;
          cnt_d[i] = 8'd0;
        end else if (cnt_q[i] + 8'd1 == LOSS_T) begin
          st_d[i]    = S_LOST;
          cnt_d[i]   = 8'd0;
          loss_ev[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
        S_LOST: if (mv[i]) begin
          if (LOCK_T == 8'd1) begin
            st_d[i]  = S_SYNC;
            cnt_d[i] = 8'd0;
          end else begin
            st_d[i]  = S_RELK;
            cnt_d[i] = 8'd1;
          end
        end
        S_RELK: if (!mv[i]) begin
          st_d[i]  = S_LOST;
          cnt_d[i] = 8'd0;
        end else if (cnt_q[i] + 8'd1 == LOCK_T) begin
          st_d[i]  = S_SYNC;
          cnt_d[i] = 8'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
        default: begin
          st_d[i]  = S_SYNC;
          cnt_d[i] = 8'd0;
        end
      endcase
      sync_d[i] = (st_d[i] == S_SYNC) || (st_d[i] == S_SUSP);
    end
  end

  logic [NOH-1:0] oh_lost_d, oh_lost_q;
  logic           all_lost_d, all_lost_q;
  logic [OHW-1:0] fb_d, fb_q;
  logic           fbv_d, fbv_q;

  always_comb begin
    oh_lost_d  = oh_lost_q | loss_ev[NOH-1:0];
    all_lost_d = all_lost_q | loss_ev[NOH];
    fb_d       = fb_q;
    fbv_d      = fbv_q;
    if (!fbv_q) begin
      for (int g = NOH - 1; g >= 0; g--) begin
        if (loss_ev[g]) begin
          fb_d  = OHW'(g);
          fbv_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      m_q        <= '1;
      mx_q       <= 1'b1;
      sync_q     <= '1;
      oh_lost_q  <= '0;
      all_lost_q <= 1'b0;
      fb_q       <= '0;
      fbv_q      <= 1'b0;
      for (int i = 0; i < NF; i++) begin
        st_q[i]  <= S_SYNC;
        cnt_q[i] <= 8'd0;
      end
    end else begin
      m_q        <= m_d;
      mx_q       <= mx_d;
      sync_q     <= sync_d;
      oh_lost_q  <= oh_lost_d;
      all_lost_q <= all_lost_d;
      fb_q       <= fb_d;
      fbv_q      <= fbv_d;
      for (int i = 0; i < NF; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef GEM_SYNC_LOSS_CNT_EN
  logic [CNTW-1:0] lc_d [NOH];
  logic [CNTW-1:0] lc_q [NOH];

  always_comb begin
    for (int g = 0; g < NOH; g++) begin
      lc_d[g] = lc_q[g];
      if (loss_ev[g] && (lc_q[g] != {CNTW{1'b1}})) begin
        lc_d[g] = lc_q[g] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int g = 0; g < NOH; g++) begin
      if (clr) begin
        lc_q[g] <= '0;
      end else begin
        lc_q[g] <= lc_d[g];
      end
    end
  end

  for (genvar g = 0; g < NOH; g++) begin : g_cnt
    assign oh_loss_cnt[g*CNTW +: CNTW] = lc_q[g];
  end
`else
  assign oh_loss_cnt = '0;
`endif

  assign oh_synced       = sync_q[NOH-1:0];
  assign all_synced      = sync_q[NOH];
  assign oh_lostsync     = oh_lost_q;
  assign all_lostsync    = all_lost_q;
  assign first_bad_oh    = fb_q;
  assign first_bad_valid = fbv_q;

endmodule

// File: doc/gem_link_sync_mon.md
# gem_link_sync_mon

Parametrised GEM fiber sync monitor for the OTMB GEM receive path. It compares the per-fiber K-character words of all GEM fibers, grouped by optohybrid (OH), and runs a debounced sync state machine per OH group plus one cross-group machine. Outputs are live sync flags, sticky lost-sync flags, saturating loss counters and a first-failing-OH capture. It sits after the GEM fiber receivers and feeds the VME status and counter registers.

## Interface
Parameters:
- NOH, 2, number of OH groups (≥1)
- FPO, 2, fibers per OH group (≥1); NFIB = NOH*FPO
- KW, 8, K-char word width
- LOSS_THRESH, 4, consecutive mismatch samples to declare loss (1..255)
- LOCK_THRESH, 16, consecutive match samples to declare relock (1..255)
- CNTW, 16, loss counter width

Ports:
- clock  in  1  single clock; all logic on rising edge
- global_reset  in  1  synchronous, active-high reset
- ttc_resync  in  1  synchronous clear of sticky flags, counters, capture and FSMs
- kchar  in  NFIB*KW  fiber f occupies bits [f*KW +: KW]; group g = fibers g*FPO..g*FPO+FPO-1
- fiber_mask  in  NFIB  1 = fiber excluded from all comparisons
- oh_synced  out  NOH  live per-group sync
- all_synced  out  1  live cross-group sync
- oh_lostsync  out  NOH  sticky per-group loss
- all_lostsync  out  1  sticky cross-group loss
- oh_loss_cnt  out  NOH*CNTW  per-group LOST-entry count, group g at [g*CNTW +: CNTW]
- first_bad_oh  out  max(1,$clog2(NOH))  first group to enter LOST since clear
- first_bad_valid  out  1  first_bad_oh holds a capture

## Operation
- Stage 1 (registered): group match m[g] = every unmasked fiber in g equals the lowest-index unmasked fiber of g; fewer than 2 unmasked fibers → m[g]=1. Cross match mx = m[] all 1 AND the reference words (lowest unmasked fiber) of all groups with ≥1 unmasked fiber are equal; fewer than 2 such groups → cross-word term = 1.
- Stage 2: NOH+1 identical FSMs (one per group on m[g], one on mx), 8-bit counter each:
  - SYNCED: mismatch → SUSPECT, cnt=1 (LOSS_THRESH=1: → LOST directly).
  - SUSPECT: mismatch → cnt+1; at cnt+1==LOSS_THRESH → LOST, cnt=0. Match → SYNCED, cnt=0.
  - LOST: match → RELOCK, cnt=1 (LOCK_THRESH=1: → SYNCED directly).
  - RELOCK: match → cnt+1; at cnt+1==LOCK_THRESH → SYNCED, cnt=0. Mismatch → LOST, cnt=0.
- synced = state ∈ {SYNCED, SUSPECT}; a single-cycle glitch never drops sync when LOSS_THRESH>1.
- On every transition into LOST: set sticky flag; group FSMs increment oh_loss_cnt, saturating at all-ones (no wrap).
- first_bad: when first_bad_valid=0 and ≥1 group FSM enters LOST, capture lowest such index and set valid; held until clear. Cross FSM never captures.
- Reset values (global_reset or ttc_resync, asserted on an edge): FSMs SYNCED, cnt=0, stage-1 match regs = 1, oh_synced/all_synced all 1, sticky flags 0, counters 0, first_bad_oh 0, first_bad_valid 0.
- ttc_resync and global_reset have identical effect; simultaneous assertion is the same as either one.
- Reset mid-SUSPECT/RELOCK discards partial counts; counting restarts from the first post-reset sample.
- fiber_mask changes take effect on the next stage-1 sample; no FSM state is altered by a mask change itself.

## Timing
- Latency input→synced: 2 cycles. A word sampled at edge e reaches stage 1 at e and the FSM at e+1.
- Nth consecutive mismatch sampled at edge e (N=LOSS_THRESH): synced low, sticky high and counter incremented after edge e+1. The same holds for relock with LOCK_THRESH.
- First post-reset sample is the edge after the reset edge. Outputs are held at reset values for that cycle.
- All outputs are registered; no combinational input→output path.

## Configuration
- GEM_SYNC_LOSS_CNT_EN defined: oh_loss_cnt counters implemented as above.
- Undefined: counters are not built and oh_loss_cnt is tied to 0. All other behaviour is unchanged.

## Test plan
- Defaults, all kchar=8'hBC for 100 cycles → all synced=1, sticky=0, counts 0, first_bad_valid=0.
- Fiber 1=8'h3C for 3 cycles, then restored → oh_synced[0] stays 1, oh_lostsync[0]=0. Repeat with 4 cycles → oh_synced[0]=0 two edges after the 4th bad sample; oh_lostsync[0]=1; oh_loss_cnt[0]=1; first_bad_oh=0, valid=1.
- After loss, 15 matching samples, 1 mismatch, then 16 matches → relock only at the end of the second run; oh_loss_cnt[0] unchanged at 1.
- Group 1 diverges on both fibers to 8'hF7 with each group internally equal → oh_synced=2'b11, all_synced falls after 4+1 cycles, all_lostsync=1.
- fiber_mask[3]=1, fiber 3 random for 50 cycles → no loss anywhere. CNTW=4 with 20 forced loss episodes → count saturates at 15. Pulse ttc_resync → all outputs return to reset values next cycle.
